// File: rtl/sc_transition_sequencer.sv
// Paces the up transition counter: clears it, steps it every PRESCALE+2 cycles, stops on target match.
// Optional macro SC_TRANSITION_SEQUENCER_AUTO_RELOAD_EN makes DONE restart the sequence instead of idling.
module sc_transition_sequencer #(
    parameter int DATAWIDTH     = 8,
    parameter int PRESCALE      = 1000000,
    parameter int PRESCALEWIDTH = 20
) (
    input  logic                 SC_transitionSEQUENCER_CLOCK_50,
    input  logic                 SC_transitionSEQUENCER_RESET_InLow,
    input  logic                 SC_transitionSEQUENCER_start_InHigh,
    input  logic                 SC_transitionSEQUENCER_abort_InHigh,
    input  logic                 SC_transitionSEQUENCER_pause_InHigh,
    input  logic [DATAWIDTH-1:0] SC_transitionSEQUENCER_target_InBUS,
    input  logic [DATAWIDTH-1:0] SC_transitionSEQUENCER_count_InBUS,
    output logic                 SC_transitionSEQUENCER_upcount_OutLow,
    output logic                 SC_transitionSEQUENCER_clear_OutHigh,
    output logic                 SC_transitionSEQUENCER_busy_OutHigh,
    output logic                 SC_transitionSEQUENCER_done_OutHigh
);

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        CLEAR = 6'b000010,
        COUNT = 6'b000100,
        STEP  = 6'b001000,
        CHECK = 6'b010000,
        DONE  = 6'b100000
    } state_t;

    localparam logic [PRESCALEWIDTH-1:0] PRESCALE_LAST = PRESCALEWIDTH'(PRESCALE - 1);

    state_t                   state, stateNext;
    logic [PRESCALEWIDTH-1:0] prescaler, prescalerNext;
    logic [DATAWIDTH-1:0]     targetReg, targetRegNext;

    always_ff @(posedge SC_transitionSEQUENCER_CLOCK_50 or negedge SC_transitionSEQUENCER_RESET_InLow) begin
        if (!SC_transitionSEQUENCER_RESET_InLow) begin
            state     <= IDLE;
            prescaler <= '0;
            targetReg <= '0;
        end else begin
            state     <= stateNext;
            prescaler <= prescalerNext;
            targetReg <= targetRegNext;
        end
    end

    always_comb begin
        stateNext     = state;
        prescalerNext = prescaler;
        targetRegNext = targetReg;
        if (SC_transitionSEQUENCER_abort_InHigh) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (SC_transitionSEQUENCER_start_InHigh) begin
                        stateNext     = CLEAR;
                        targetRegNext = SC_transitionSEQUENCER_target_InBUS;
                    end
                end
                CLEAR: stateNext = CHECK;
                CHECK: begin
                    if (SC_transitionSEQUENCER_count_InBUS == targetReg) begin
                        stateNext = DONE;
                    end else begin
                        stateNext     = COUNT;
                        prescalerNext = '0;
                    end
                end
                COUNT: begin
                    if (!SC_transitionSEQUENCER_pause_InHigh) begin
                        if (prescaler == PRESCALE_LAST) begin
                            stateNext = STEP;
                        end else begin
                            prescalerNext = prescaler + PRESCALEWIDTH'(1);
                        end
                    end
                end
                STEP: stateNext = CHECK;
                DONE: begin
`ifdef SC_TRANSITION_SEQUENCER_AUTO_RELOAD_EN
                    stateNext = CLEAR;
`else
                    stateNext = IDLE;
`endif
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Outputs come straight off one-hot state bits so the async clear never glitches.
    assign SC_transitionSEQUENCER_clear_OutHigh  = state[1];
    assign SC_transitionSEQUENCER_upcount_OutLow = ~state[3];
    assign SC_transitionSEQUENCER_done_OutHigh   = state[5];
    assign SC_transitionSEQUENCER_busy_OutHigh   = ~state[0];

endmodule
